// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and the decode stage.
// master = fetch unit side, slave = memory + decode side.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [DATA_W-1:0] imem_rdata;
    logic              inst_valid;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC generation, credit-limited imem reads, prefetch FIFO, redirect flush.
// Optional performance counters are enabled with the IFU_PERF_CNT_EN macro.
module instr_fetch_unit #(
    parameter int                ADDR_W          = 32,
    parameter int                DATA_W          = 32,
    parameter int                FIFO_DEPTH      = 4,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [ADDR_W-1:0] RESET_PC        = '0
) (
    input  logic              clk,
    input  logic              reset,
    instr_fetch_unit_if.master bus,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_flushes,
`endif
    output logic              busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] fetch_pc, resp_pc;
    logic [CNT_W-1:0]  outstanding, outstanding_next;
    logic [CNT_W-1:0]  stale, stale_next;
    logic [CNT_W-1:0]  fifo_count;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic              credit_ok, grant, push, pop;

    // Credits cover both in-flight reads and queued words, so a response always has a free slot.
    assign credit_ok = (outstanding < MAX_OUT_C) &&
                       (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_C);

    assign bus.imem_req   = reset && (state == RUN) && credit_ok;
    assign bus.imem_addr  = fetch_pc;
    assign bus.inst_valid = (fifo_count != '0);
    assign bus.inst_data  = fifo_data[rd_ptr];
    assign bus.inst_pc    = fifo_pc[rd_ptr];
    assign busy           = (outstanding != '0) || (stale != '0) || (fifo_count != '0);

    assign grant = bus.imem_req && bus.imem_gnt;
    assign push  = bus.imem_rvalid && (stale == '0) && !redirect;
    assign pop   = bus.inst_valid && bus.inst_ready;

    always_comb begin
        state_next       = state;
        outstanding_next = outstanding;
        stale_next       = stale;
        if (redirect) begin
            outstanding_next = '0;
            stale_next       = stale + outstanding + CNT_W'(grant) - CNT_W'(bus.imem_rvalid);
        end else begin
            if (bus.imem_rvalid) begin
                if (stale != '0) stale_next = stale - 1'b1;
                else             outstanding_next = outstanding - 1'b1;
            end
            if (grant) outstanding_next = outstanding_next + 1'b1;
        end
        state_next = (stale_next != '0) ? DRAIN : RUN;
    end

    // Responses return in grant order and grants are sequential, so one running tag
    // tracks the pc of the next non-stale response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            outstanding <= '0;
            stale       <= '0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            stale       <= stale_next;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                resp_pc  <= redirect_pc;
            end else begin
                if (grant) fetch_pc <= fetch_pc + 1'b1;
                if (push)  resp_pc  <= resp_pc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_count <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else if (redirect) begin
            fifo_count <= '0;
            rd_ptr     <= wr_ptr;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]   <= resp_pc;
                fifo_data[wr_ptr] <= bus.imem_rdata;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
        end else begin
            if (pop && (perf_fetched != '1))      perf_fetched <= perf_fetched + 1'b1;
            if (redirect && (perf_flushes != '1)) perf_flushes <= perf_flushes + 1'b1;
        end
    end
`endif
endmodule
